// File: rtl/line_rasterizer.sv
// Bresenham line rasterizer: accepts endpoint pairs in IDLE and streams every
// pixel of the line over a valid/ready handshake, then pulses done.
module line_rasterizer #(
    parameter int COORD_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    output logic               busy,
    output logic               pix_valid,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    input  logic               pix_ready,
    output logic               done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_DRAW  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [COORD_W-1:0]        r_x0, r_y0, r_x1, r_y1;
    logic [COORD_W-1:0]        r_dx, r_dy;
    logic                      r_sx_neg, r_sy_neg;
    logic signed [COORD_W+1:0] r_err;
    logic [COORD_W-1:0]        r_pix_x, r_pix_y;

    logic                      w_xfer;
    logic                      w_at_end;
    logic [COORD_W-1:0]        w_dx, w_dy;
    logic signed [COORD_W+2:0] w_e2, w_neg_dy, w_dx_ext;
    logic                      w_step_x, w_step_y;
    logic signed [COORD_W+1:0] w_err_sub, w_err_add, w_err_nxt;

    assign w_xfer   = (r_state == S_DRAW) && pix_ready;
    assign w_at_end = (r_pix_x == r_x1) && (r_pix_y == r_y1);

    assign w_dx = (r_x1 >= r_x0) ? (r_x1 - r_x0) : (r_x0 - r_x1);
    assign w_dy = (r_y1 >= r_y0) ? (r_y1 - r_y0) : (r_y0 - r_y1);

    // Decision terms use the error value held before this step's update.
    assign w_e2     = {r_err, 1'b0};
    assign w_neg_dy = -$signed({3'b000, r_dy});
    assign w_dx_ext = $signed({3'b000, r_dx});
    assign w_step_x = (w_e2 > w_neg_dy);
    assign w_step_y = (w_e2 < w_dx_ext);

    assign w_err_sub = w_step_x ? {2'b00, r_dy} : {(COORD_W+2){1'b0}};
    assign w_err_add = w_step_y ? {2'b00, r_dx} : {(COORD_W+2){1'b0}};
    assign w_err_nxt = r_err - w_err_sub + w_err_add;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_SETUP;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SETUP: w_state_nxt = S_DRAW;
            S_DRAW: begin
                if (w_xfer && w_at_end) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_DRAW;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode from the registered state
    always_comb begin
        busy      = 1'b0;
        pix_valid = 1'b0;
        done      = 1'b0;
        case (r_state)
            S_IDLE:  busy = 1'b0;
            S_SETUP: busy = 1'b1;
            S_DRAW: begin
                busy      = 1'b1;
                pix_valid = 1'b1;
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: busy = 1'b0;
        endcase
    end

    // Coordinate capture, setup arithmetic and pixel stepping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x0     <= {COORD_W{1'b0}};
            r_y0     <= {COORD_W{1'b0}};
            r_x1     <= {COORD_W{1'b0}};
            r_y1     <= {COORD_W{1'b0}};
            r_dx     <= {COORD_W{1'b0}};
            r_dy     <= {COORD_W{1'b0}};
            r_sx_neg <= 1'b0;
            r_sy_neg <= 1'b0;
            r_err    <= {(COORD_W+2){1'b0}};
            r_pix_x  <= {COORD_W{1'b0}};
            r_pix_y  <= {COORD_W{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_x0 <= x0;
                        r_y0 <= y0;
                        r_x1 <= x1;
                        r_y1 <= y1;
                    end else begin
                        r_x0 <= r_x0;
                    end
                end
                S_SETUP: begin
                    r_dx     <= w_dx;
                    r_dy     <= w_dy;
                    r_sx_neg <= (r_x1 < r_x0);
                    r_sy_neg <= (r_y1 < r_y0);
                    r_err    <= $signed({2'b00, w_dx}) - $signed({2'b00, w_dy});
                    r_pix_x  <= r_x0;
                    r_pix_y  <= r_y0;
                end
                S_DRAW: begin
                    // The endpoint is never stepped past, so coordinates cannot wrap.
                    if (w_xfer && !w_at_end) begin
                        r_err <= w_err_nxt;
                        if (w_step_x) begin
                            r_pix_x <= r_sx_neg ? (r_pix_x - {{(COORD_W-1){1'b0}}, 1'b1})
                                                : (r_pix_x + {{(COORD_W-1){1'b0}}, 1'b1});
                        end else begin
                            r_pix_x <= r_pix_x;
                        end
                        if (w_step_y) begin
                            r_pix_y <= r_sy_neg ? (r_pix_y - {{(COORD_W-1){1'b0}}, 1'b1})
                                                : (r_pix_y + {{(COORD_W-1){1'b0}}, 1'b1});
                        end else begin
                            r_pix_y <= r_pix_y;
                        end
                    end else begin
                        r_err <= r_err;
                    end
                end
                default: r_err <= r_err;
            endcase
        end
    end

    assign pix_x = r_pix_x;
    assign pix_y = r_pix_y;

endmodule

// File: doc/line_rasterizer.md
LINE_RASTERIZER -- requirements
Module: line_rasterizer

Interface
REQ-001 SHALL have parameter: COORD_W, 8, coordinate width in bits (all verification at default).
REQ-002 SHALL have one clock; reset is asynchronous and active-high. Ports are clk and rst.
REQ-003 SHALL have port: clk  input  1  rising-edge clock.
REQ-004 SHALL have port: rst  input  1  asynchronous active-high reset.
REQ-005 SHALL have port: start  input  1  one-cycle line request from the controller, sampled in IDLE only.
REQ-006 SHALL have port: x0  input  COORD_W  start x, sampled with start.
REQ-007 SHALL have port: y0  input  COORD_W  start y, sampled with start.
REQ-008 SHALL have port: x1  input  COORD_W  end x, sampled with start.
REQ-009 SHALL have port: y1  input  COORD_W  end y, sampled with start.
REQ-010 SHALL have port: busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port: pix_valid  output  1  pixel coordinate available.
REQ-012 SHALL have port: pix_x  output  COORD_W  current pixel x.
REQ-013 SHALL have port: pix_y  output  COORD_W  current pixel y.
REQ-014 SHALL have port: pix_ready  input  1  downstream framebuffer writer accepts the pixel.
REQ-015 SHALL have port: done  output  1  one-cycle pulse after the last pixel is accepted.

Function
REQ-016 SHALL implement the FSM states IDLE, SETUP, DRAW and DONE.
REQ-017 SHALL move IDLE->SETUP on start=1; SHALL ignore start in every other state.
REQ-018 SHALL, on entering SETUP, register x0, y0, x1, y1; SHALL in SETUP compute dx=|x1-x0| and dy=|y1-y0| (COORD_W unsigned), sx=+1 if x1>=x0 else -1, sy=+1 if y1>=y0 else -1, err=dx-dy (COORD_W+2 bit signed); SHALL then go to DRAW.
REQ-019 SHALL drive pix_valid=1 only in DRAW; first pix_valid on cycle N+2 for start at cycle N.
REQ-020 SHALL hold pix_x, pix_y and err stable while pix_valid=1 and pix_ready=0.
REQ-021 SHALL treat a transfer as pix_valid=1 and pix_ready=1 on the same rising edge.
REQ-022 SHALL, on a transfer where (pix_x,pix_y)==(x1,y1), go to DONE.
REQ-023 SHALL, on any other transfer, compute e2=2*err (COORD_W+3 bit signed) from the pre-update err.
REQ-024 SHALL, if e2 > -dy, subtract dy from err and add sx to pix_x.
REQ-025 SHALL, if e2 < dx, add dx to err and add sy to pix_y; both updates SHALL apply in the same cycle when both conditions hold.
REQ-026 SHALL emit exactly max(dx,dy)+1 pixels per line; coordinates SHALL never wrap, since stepping stops at the endpoint.
REQ-027 SHALL, in DONE, assert done=1 for exactly one cycle with pix_valid=0, then return to IDLE; a start in that IDLE cycle SHALL be accepted.
REQ-028 SHALL handle a degenerate line (x0==x1 and y0==y1) as a single pixel followed by DONE.

Reset
REQ-029 SHALL, while rst=1, force state=IDLE, busy=0, pix_valid=0, done=0, pix_x=0, pix_y=0, and clear internal registers, independent of clk.
REQ-030 SHALL, when rst asserts mid-line, abandon the line immediately with no further pixels or done; after release the block SHALL wait in IDLE for a new start.

Verification
REQ-031 SHALL verify the horizontal line: start (0,0)->(3,0), pix_ready=1 -> pixels (0,0),(1,0),(2,0),(3,0) on consecutive cycles, then done one cycle later.
REQ-032 SHALL verify the shallow slope: (0,0)->(4,2) -> pixels (0,0),(1,0),(2,1),(3,1),(4,2) in order.
REQ-033 SHALL verify the reverse diagonal and single point: (3,3)->(0,0) -> (3,3),(2,2),(1,1),(0,0); (5,5)->(5,5) -> exactly one pixel (5,5), then done.
REQ-034 SHALL verify backpressure: (0,0)->(3,0) with pix_ready low 3 cycles on pixel (1,0) -> (1,0) held stable those cycles, then the sequence continues unchanged and busy stays 1 throughout.
REQ-035 SHALL verify the extremes and reset: (0,0)->(255,0) -> 256 pixels with no wrap; rst pulsed after the 2nd pixel of (0,0)->(0,9) -> pix_valid=0, busy=0 immediately, no done, and the next start draws correctly.
